// File: rtl/sn74xx_updown_counter_n_pkg.sv
// Common types and constants for the parametrised up/down counter.
package sn74xx_updown_counter_n_pkg;

  `include "sn74xx_timing.vh"

  // Operation selected for the next clock edge (clear is handled separately).
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } op_e;

  // A delay triple is sane when min <= typ <= max and nothing is negative.
  function automatic bit delay_triple_ok(input int dmin, input int dtyp, input int dmax);
    return (dmin >= 0) && (dmin <= dtyp) && (dtyp <= dmax);
  endfunction

endpackage

// File: rtl/sn74xx_tc_detect.sv
// Terminal-count comparator: flags the last state of the count in the
// current direction, gated by the cascade enable ent.
module sn74xx_tc_detect
  import sn74xx_updown_counter_n_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             ent,
  output logic             rco
);

  localparam logic [WIDTH-1:0] TC_UP = WIDTH'(MODULUS - 1);

  // Equality against MODULUS-1 means an out-of-range q can never flag in the up direction.
  always_comb begin
    if (up == COUNT_UP) rco = ent & (q == TC_UP);
    else                rco = ent & (q == '0);
  end

endmodule

// File: rtl/sn74xx_timing.vh
// Shared defaults for the sn74xx counter family: delay triples (ns) and
// count-direction encodings.
`ifndef SN74XX_TIMING_VH
`define SN74XX_TIMING_VH

localparam int SN74XX_TPLHQ_MIN = 0;
localparam int SN74XX_TPLHQ_TYP = 13;
localparam int SN74XX_TPLHQ_MAX = 20;
localparam int SN74XX_TPHLQ_MIN = 0;
localparam int SN74XX_TPHLQ_TYP = 15;
localparam int SN74XX_TPHLQ_MAX = 23;
localparam int SN74XX_TPLHR_MIN = 0;
localparam int SN74XX_TPLHR_TYP = 10;
localparam int SN74XX_TPLHR_MAX = 15;
localparam int SN74XX_TPHLR_MIN = 0;
localparam int SN74XX_TPHLR_TYP = 12;
localparam int SN74XX_TPHLR_MAX = 18;

localparam logic COUNT_UP   = 1'b1;
localparam logic COUNT_DOWN = 1'b0;

`endif

// File: rtl/sn74xx_updown_counter_n.sv
// Fully synchronous presettable up/down modulo-N counter with TTL-style
// enables (enp/ent), ripple-carry (rco) and ripple-clock (rck_n) outputs
// for cascading. The RTL is zero-delay; the delay parameters describe the
// device for back-annotated timing.
module sn74xx_updown_counter_n
  import sn74xx_updown_counter_n_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int tPLHQ_min = SN74XX_TPLHQ_MIN,
  parameter int tPLHQ_typ = SN74XX_TPLHQ_TYP,
  parameter int tPLHQ_max = SN74XX_TPLHQ_MAX,
  parameter int tPHLQ_min = SN74XX_TPHLQ_MIN,
  parameter int tPHLQ_typ = SN74XX_TPHLQ_TYP,
  parameter int tPHLQ_max = SN74XX_TPHLQ_MAX,
  parameter int tPLHR_min = SN74XX_TPLHR_MIN,
  parameter int tPLHR_typ = SN74XX_TPLHR_TYP,
  parameter int tPLHR_max = SN74XX_TPLHR_MAX,
  parameter int tPHLR_min = SN74XX_TPHLR_MIN,
  parameter int tPHLR_typ = SN74XX_TPHLR_TYP,
  parameter int tPHLR_max = SN74XX_TPHLR_MAX
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             rck_n
);

  localparam logic [WIDTH-1:0] TC_UP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  localparam bit PARAMS_OK =
    (WIDTH >= 1) && (WIDTH <= 16) &&
    (MODULUS >= 2) && (MODULUS <= (1 << WIDTH)) &&
    delay_triple_ok(tPLHQ_min, tPLHQ_typ, tPLHQ_max) &&
    delay_triple_ok(tPHLQ_min, tPHLQ_typ, tPHLQ_max) &&
    delay_triple_ok(tPLHR_min, tPLHR_typ, tPLHR_max) &&
    delay_triple_ok(tPHLR_min, tPHLR_typ, tPHLR_max);

  if (!PARAMS_OK) begin : g_param_check
    $error("sn74xx_updown_counter_n: illegal WIDTH/MODULUS or delay parameters");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  op_e              op;

  // Next-state: load beats count beats hold. Out-of-range states fall to 0
  // going up and step down one at a time going down, so nothing locks up.
  always_comb begin
    op  = OP_HOLD;
    q_d = q_q;
    if (!load_n)          op = OP_LOAD;
    else if (enp && ent)  op = OP_COUNT;
    case (op)
      OP_LOAD:  q_d = d;
      OP_COUNT: begin
        if (up == COUNT_UP) q_d = (q_q >= TC_UP) ? '0 : q_q + ONE;
        else                q_d = (q_q == '0) ? TC_UP : q_q - ONE;
      end
      default:  q_d = q_q;
    endcase
  end

  // State register; clr wins over everything on its edge. No power-on value,
  // so q stays unknown until the first clear.
  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

  sn74xx_tc_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc_detect (
    .q   (q_q),
    .up  (up),
    .ent (ent),
    .rco (rco)
  );

  // Ripple clock: low during the clk-low phase ahead of a terminal-count edge.
  assign rck_n = ~(rco & enp & ~clk);

endmodule

// File: tb/tb_sn74xx_updown_counter_n.sv
// Directed bench for sn74xx_updown_counter_n: decade, down wrap, priority,
// enable split, out-of-range load and a two-stage cascade.
module tb_sn74xx_updown_counter_n;

  logic       clk = 1'b0;
  logic       clr, load_n, enp, ent, up;
  logic [3:0] d;
  logic [3:0] q10, q12, q16;
  logic       rco10, rco12, rco16, rckn10, rckn12, rckn16;

  logic       c_clr, c_one;
  logic [3:0] c_d;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco, lo_rckn, hi_rckn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sn74xx_updown_counter_n #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .clr(clr), .load_n(load_n), .enp(enp), .ent(ent), .up(up),
    .d(d), .q(q10), .rco(rco10), .rck_n(rckn10));

  sn74xx_updown_counter_n #(.WIDTH(4), .MODULUS(12)) dut12 (
    .clk(clk), .clr(clr), .load_n(load_n), .enp(enp), .ent(ent), .up(up),
    .d(d), .q(q12), .rco(rco12), .rck_n(rckn12));

  sn74xx_updown_counter_n #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .clr(clr), .load_n(load_n), .enp(enp), .ent(ent), .up(up),
    .d(d), .q(q16), .rco(rco16), .rck_n(rckn16));

  sn74xx_updown_counter_n #(.WIDTH(4), .MODULUS(16)) lo (
    .clk(clk), .clr(c_clr), .load_n(c_one), .enp(c_one), .ent(c_one), .up(c_one),
    .d(c_d), .q(lo_q), .rco(lo_rco), .rck_n(lo_rckn));

  sn74xx_updown_counter_n #(.WIDTH(4), .MODULUS(16)) hi (
    .clk(clk), .clr(c_clr), .load_n(c_one), .enp(c_one), .ent(lo_rco), .up(c_one),
    .d(c_d), .q(hi_q), .rco(hi_rco), .rck_n(hi_rckn));

  task automatic test_reset();
    clr = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b1; up = 1'b0; d = 4'd0;
    c_clr = 1'b1; c_one = 1'b1; c_d = 4'd0;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL reset_q10: got %0d expected 0", q10); end
    checks++; if (q12 !== 4'd0) begin errors++; $display("FAIL reset_q12: got %0d expected 0", q12); end
    checks++; if (q16 !== 4'd0) begin errors++; $display("FAIL reset_q16: got %0d expected 0", q16); end
    checks++; if ({hi_q, lo_q} !== 8'd0) begin errors++; $display("FAIL reset_cascade: got %0d expected 0", {hi_q, lo_q}); end
    checks++; if (rco10 !== 1'b1) begin errors++; $display("FAIL reset_rco_down: got %b expected 1", rco10); end
    checks++; if (rckn10 !== 1'b1) begin errors++; $display("FAIL reset_rckn: got %b expected 1", rckn10); end
    up = 1'b1; #1;
    checks++; if (rco10 !== 1'b0) begin errors++; $display("FAIL reset_rco_up: got %b expected 0", rco10); end
  endtask

  task automatic test_decade();
    logic [3:0] exp;
    clr = 1'b0; load_n = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp = 4'(i % 10);
      checks++; if (q10 !== exp) begin errors++; $display("FAIL decade_q[%0d]: got %0d expected %0d", i, q10, exp); end
      checks++; if (rco10 !== (exp == 4'd9)) begin errors++; $display("FAIL decade_rco[%0d]: got %b expected %b", i, rco10, exp == 4'd9); end
      checks++; if (rckn10 !== 1'b1) begin errors++; $display("FAIL decade_rckn_hi[%0d]: got %b expected 1", i, rckn10); end
      @(negedge clk); #1;
      checks++; if (rckn10 !== (exp != 4'd9)) begin errors++; $display("FAIL decade_rckn_lo[%0d]: got %b expected %b", i, rckn10, exp != 4'd9); end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd1, 4'd0, 4'd9, 4'd8};
    load_n = 1'b0; d = 4'd2; up = 1'b0; enp = 1'b1; ent = 1'b1;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd2) begin errors++; $display("FAIL down_load: got %0d expected 2", q10); end
    load_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (q10 !== exp_seq[i]) begin errors++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q10, exp_seq[i]); end
      checks++; if (rco10 !== (exp_seq[i] == 4'd0)) begin errors++; $display("FAIL down_rco[%0d]: got %b expected %b", i, rco10, exp_seq[i] == 4'd0); end
    end
  endtask

  task automatic test_priority();
    load_n = 1'b0; d = 4'd5; enp = 1'b0; ent = 1'b1; up = 1'b1;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL prio_setup: got %0d expected 5", q10); end
    clr = 1'b1; load_n = 1'b0; d = 4'd7; enp = 1'b1; ent = 1'b1;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd0) begin errors++; $display("FAIL prio_clr: got %0d expected 0", q10); end
    clr = 1'b0;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd7) begin errors++; $display("FAIL prio_load: got %0d expected 7", q10); end
    load_n = 1'b1; enp = 1'b0;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd7) begin errors++; $display("FAIL prio_hold: got %0d expected 7", q10); end
  endtask

  task automatic test_enable_split();
    load_n = 1'b0; d = 4'd15; up = 1'b1; enp = 1'b0; ent = 1'b1;
    @(posedge clk); #1;
    load_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (q16 !== 4'd15) begin errors++; $display("FAIL split_enp0_q: got %0d expected 15", q16); end
    checks++; if (rco16 !== 1'b1) begin errors++; $display("FAIL split_enp0_rco: got %b expected 1", rco16); end
    @(negedge clk); #1;
    checks++; if (rckn16 !== 1'b1) begin errors++; $display("FAIL split_enp0_rckn: got %b expected 1", rckn16); end
    ent = 1'b0;
    @(posedge clk); #1;
    checks++; if (q16 !== 4'd15) begin errors++; $display("FAIL split_ent0_q: got %0d expected 15", q16); end
    checks++; if (rco16 !== 1'b0) begin errors++; $display("FAIL split_ent0_rco: got %b expected 0", rco16); end
    enp = 1'b1;
    @(posedge clk); #1;
    checks++; if (q16 !== 4'd15) begin errors++; $display("FAIL split_enp1_ent0_q: got %0d expected 15", q16); end
    ent = 1'b1;
    @(posedge clk); #1;
    checks++; if (q16 !== 4'd0) begin errors++; $display("FAIL split_binary_wrap: got %0d expected 0", q16); end
  endtask

  task automatic test_out_of_range();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd13, 4'd12, 4'd11, 4'd10};
    load_n = 1'b0; d = 4'd14; up = 1'b1; enp = 1'b1; ent = 1'b1;
    @(posedge clk); #1;
    checks++; if (q12 !== 4'd14) begin errors++; $display("FAIL oor_load_up: got %0d expected 14", q12); end
    checks++; if (rco12 !== 1'b0) begin errors++; $display("FAIL oor_rco_load_up: got %b expected 0", rco12); end
    load_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (q12 !== 4'd0) begin errors++; $display("FAIL oor_up_step: got %0d expected 0", q12); end
    checks++; if (rco12 !== 1'b0) begin errors++; $display("FAIL oor_rco_up_step: got %b expected 0", rco12); end
    load_n = 1'b0; up = 1'b0;
    @(posedge clk); #1;
    checks++; if (q12 !== 4'd14) begin errors++; $display("FAIL oor_reload: got %0d expected 14", q12); end
    load_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (q12 !== exp_seq[i]) begin errors++; $display("FAIL oor_down_q[%0d]: got %0d expected %0d", i, q12, exp_seq[i]); end
      checks++; if (rco12 !== 1'b0) begin errors++; $display("FAIL oor_down_rco[%0d]: got %b expected 0", i, rco12); end
    end
  endtask

  task automatic test_back_to_back_direction();
    load_n = 1'b0; d = 4'd4; enp = 1'b1; ent = 1'b1; up = 1'b1;
    @(posedge clk); #1;
    load_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL dir_up: got %0d expected 5", q10); end
    up = 1'b0;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd4) begin errors++; $display("FAIL dir_down: got %0d expected 4", q10); end
    up = 1'b1;
    @(posedge clk); #1;
    checks++; if (q10 !== 4'd5) begin errors++; $display("FAIL dir_up_again: got %0d expected 5", q10); end
  endtask

  task automatic test_cascade();
    logic [7:0] exp;
    c_clr = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      exp = 8'(i % 256);
      checks++; if ({hi_q, lo_q} !== exp) begin errors++; $display("FAIL cascade_q[%0d]: got %0d expected %0d", i, {hi_q, lo_q}, exp); end
      checks++; if (hi_rco !== (exp == 8'd255)) begin errors++; $display("FAIL cascade_hi_rco[%0d]: got %b expected %b", i, hi_rco, exp == 8'd255); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decade();
    test_down_wrap();
    test_priority();
    test_enable_split();
    test_out_of_range();
    test_back_to_back_direction();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
